// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;

   // Saturating increment used by the per-requester beat counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index at or after ptr, modulo N.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   int            sum;
   logic [IW-1:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = 0;
      cand  = '0;
      // Scan from the farthest offset down so the nearest valid index is the one left standing.
      for (int i = N - 1; i >= 0; i--) begin
         sum = int'(ptr) + i;
         if (sum >= N) sum = sum - N;
         cand = IW'(sum);
         if (valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional per-requester accepted-beat counters behind macro FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_enq,
   output logic [WIDTH-1:0]           fifo_data_in,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
`ifdef FIFO_ARB_STATS_EN
   output logic [NUM_REQ*STAT_W-1:0]  beat_count,
`endif
   output logic                       busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);
   localparam logic [IW-1:0] TOP_IDX  = IW'(NUM_REQ - 1);

   arb_state_t    state;
   logic [IW-1:0] rr_ptr;
   logic [BW-1:0] beat_cnt;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          accept;
   logic          burst_end;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // The write port is a pure mux of the owner; an aborted burst drops it the moment state leaves BURST.
   always_comb begin
      fifo_enq     = 1'b0;
      req_ready    = '0;
      fifo_data_in = req_data[int'(grant_id)*WIDTH +: WIDTH];
      if (state == BURST) begin
         fifo_enq            = req_valid[grant_id] & ~fifo_full;
         req_ready[grant_id] = ~fifo_full;
      end
   end

   assign accept    = fifo_enq;
   assign burst_end = req_last[grant_id] | (beat_cnt == LAST_CNT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  beat_cnt <= '0;
                  state    <= BURST;
                  busy     <= 1'b1;
               end
            end
            BURST: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (burst_end) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     rr_ptr <= (grant_id == TOP_IDX) ? '0 : grant_id + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] stat_cnt [NUM_REQ];

   // NOTE: this array is reset because the counters are software-visible state, not bulk storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      end else if (accept) begin
         stat_cnt[grant_id] <= sat_inc(stat_cnt[grant_id]);
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign beat_count[g*STAT_W +: STAT_W] = stat_cnt[g];
   end
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port, minimum 2.
REQ-002 SHALL have parameter WIDTH, default 32: data width, equal to the downstream FIFO width.
REQ-003 SHALL have parameter MAX_BURST, default 8: maximum beats per grant, minimum 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-007 SHALL have port req_data, input, NUM_REQ x WIDTH packed, per-requester beat data.
REQ-008 SHALL have port req_last, input, NUM_REQ, final beat of the requester's burst.
REQ-009 SHALL have port req_ready, output, NUM_REQ, beat accepted this cycle when high with req_valid.
REQ-010 SHALL have port fifo_full, input, 1, full flag of the downstream FIFO.
REQ-011 SHALL have port fifo_enq, output, 1, FIFO enqueue strobe.
REQ-012 SHALL have port fifo_data_in, output, WIDTH, FIFO write data.
REQ-013 SHALL have port grant_id, output, $clog2(NUM_REQ), index of the current owner.
REQ-014 SHALL have port busy, output, 1, high while in state BURST.

Function
REQ-015 SHALL implement the states IDLE and BURST.
REQ-016 In IDLE with any req_valid high, SHALL register as winner the first valid index at or after rr_ptr (modulo NUM_REQ), load grant_id, clear beat_cnt and enter BURST next cycle; with no valid, SHALL stay in IDLE.
REQ-017 SHALL spend one arbitration cycle: no beat is accepted in the IDLE cycle.
REQ-018 In BURST, SHALL drive combinationally fifo_enq = req_valid[grant_id] & ~fifo_full, req_ready[grant_id] = ~fifo_full, all other req_ready = 0, fifo_data_in = req_data[grant_id].
REQ-019 In IDLE, SHALL hold fifo_enq and all req_ready at 0.
REQ-020 On each accepted beat, SHALL increment beat_cnt (width $clog2(MAX_BURST+1)).
REQ-021 SHALL return to IDLE after an accepted beat with req_last[grant_id]=1, or when beat_cnt reaches MAX_BURST, whichever is first, and SHALL set rr_ptr = (grant_id+1) mod NUM_REQ.
REQ-022 If the owner drops req_valid mid-burst, SHALL keep the grant (no preemption) and stall.
REQ-023 If fifo_full=1, SHALL accept no beat and keep the state and beat_cnt.
REQ-024 SHALL ignore req_last outside an accepted beat.

Reset
REQ-025 While rst=1, SHALL force state IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, fifo_enq=0, req_ready=0, and counters (REQ-027) =0, asynchronously; rst asserted mid-burst SHALL abort the burst with no further enq.

Configuration
REQ-026 SHALL use macro FIFO_ARB_STATS_EN.
REQ-027 With FIFO_ARB_STATS_EN defined, SHALL add output beat_count (NUM_REQ x 16), holding per-requester accepted-beat counters that saturate at 16'hFFFF.
REQ-028 Without FIFO_ARB_STATS_EN, SHALL have no beat_count port or counter logic; other behaviour SHALL be identical.

Structure
REQ-029 SHALL place the state enum (IDLE, BURST) and the counter width constant STAT_W=16 in package fifo_arb_pkg.
REQ-030 SHALL be one sub-module, rr_pick (parameter N; inputs valid[N], ptr; outputs found, idx), the combinational round-robin selector.

Verification
REQ-031 Bench SHALL cover: NUM_REQ=4, only req 2 valid, 3 beats, last on beat 3 -> one idle cycle, then fifo_enq for 3 consecutive cycles with grant_id=2, then IDLE and rr_ptr=3.
REQ-032 Bench SHALL cover: all 4 valid, single-beat bursts -> grants in order 0,1,2,3,0, with each grant taking 2 cycles.
REQ-033 Bench SHALL cover: MAX_BURST=8, req 1 streams 12 beats with no last -> after 8 beats IDLE, req 1 re-granted only after other valid requesters.
REQ-034 Bench SHALL cover: fifo_full held 3 cycles mid-burst -> fifo_enq=0 and req_ready=0 for those cycles, no beat lost or duplicated.
REQ-035 Bench SHALL cover: rst pulsed during BURST beat 2 -> same-cycle fifo_enq=0, busy=0; after release, arbitration restarts from index 0.
REQ-036 Bench SHALL cover: with FIFO_ARB_STATS_EN, 70000 beats from req 0 -> beat_count[0]=16'hFFFF, other counters 0.
